// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam logic [31:0] PC_INCREMENT     = 32'h4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned ENTRY_W          = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Synchronous FIFO holding fetched {pc, inst} entries; flush empties it in one cycle.
module if_fetch_buf #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_data,
   input  logic                         i_pop,
   input  logic                         i_flush,
   output logic [$clog2(DEPTH):0]       o_count,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [WIDTH-1:0]             o_head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full buffer is accepted only when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (!rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding imem read at a time,
// buffers returned words with their PCs and handles redirects (flushing stale fetches).
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_ce,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
);

   localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic [31:0]  r_fetch_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  r_addr;
   logic [31:0]  w_addr_nxt;
   logic         r_req;
   logic         w_req_nxt;

   logic         w_ack;
   logic         w_pop;
   logic         w_push;
   logic         w_flush;
   logic [31:0]  w_redir_pc;
   logic [31:0]  w_pc_inc;
   logic [CW-1:0] w_count;
   logic [CW:0]  w_occ;
   logic         w_full;
   logic         w_empty;
   logic         w_space_idle;
   logic         w_space_req;
   if_entry_t    w_push_entry;
   if_entry_t    w_head;

   assign w_ack        = imem_ack && r_req;
   assign w_pop        = !w_empty && if_ready;
   assign w_redir_pc   = align_pc(redirect_pc);
   assign w_pc_inc     = r_fetch_pc + PC_INCREMENT;
   assign w_push_entry = '{pc: r_fetch_pc, inst: imem_rdata};

   // Both issue points leave nothing outstanding afterwards, so space reduces to
   // occupancy after this cycle's pop (and, in REQ, this cycle's push) being below depth.
   assign w_space_idle = !w_full || w_pop;
   assign w_occ        = (CW+1)'(w_count) + (CW+1)'(1) - (CW+1)'(w_pop);
   assign w_space_req  = (w_occ < (CW+1)'(BUF_DEPTH));

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_fetch_pc;
      w_addr_nxt  = r_addr;
      w_req_nxt   = r_req;
      w_push      = 1'b0;
      w_flush     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               w_flush  = 1'b1;
            end else if (inst_ce && w_space_idle) begin
               w_state_nxt = REQ;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_fetch_pc;
            end
         end
         REQ: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               w_flush  = 1'b1;
               if (w_ack) begin
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
               end else begin
                  w_state_nxt = DROP;
               end
            end else if (w_ack) begin
               w_push   = 1'b1;
               w_pc_nxt = w_pc_inc;
               if (inst_ce && w_space_req) begin
                  w_addr_nxt = w_pc_inc;
               end else begin
                  w_state_nxt = IDLE;
                  w_req_nxt   = 1'b0;
               end
            end
         end
         DROP: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               w_flush  = 1'b1;
            end
            if (w_ack) begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_addr     <= RESET_PC;
         r_req      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_pc_nxt;
         r_addr     <= w_addr_nxt;
         r_req      <= w_req_nxt;
      end
   end

   if_fetch_buf #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (w_push_entry),
      .i_pop       (w_pop),
      .i_flush     (w_flush),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   assign imem_req  = r_req;
   assign imem_addr = r_addr;
   assign if_valid  = !w_empty;
   assign if_inst   = w_empty ? '0 : w_head.inst;
   assign if_pc     = w_empty ? '0 : w_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus a wrap/mid-reset sequence.
module tb_if_fetch_unit;

   typedef struct {
      bit          rst;
      bit          ce;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          hold;
      bit          e_req;
      bit          chk_addr;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, inst_ce, imem_req, imem_ack, redirect_valid, if_valid, if_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, if_inst, if_pc;
   logic        ack_hold;

   logic        rst2, req2, valid2;
   logic [31:0] addr2, inst2, pc2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign imem_ack   = imem_req && !ack_hold;
   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .inst_ce        (inst_ce),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_inst        (if_inst),
      .if_pc          (if_pc)
   );

   if_fetch_unit #(
      .RESET_PC  (32'hFFFF_FFFC),
      .BUF_DEPTH (2)
   ) dut_wrap (
      .clk            (clk),
      .rst            (rst2),
      .inst_ce        (1'b1),
      .imem_req       (req2),
      .imem_addr      (addr2),
      .imem_ack       (req2),
      .imem_rdata     (addr2 ^ 32'hA5A5_0000),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .if_valid       (valid2),
      .if_ready       (1'b1),
      .if_inst        (inst2),
      .if_pc          (pc2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t V(bit r, bit ce, bit rdy, bit rv, logic [31:0] rpc, bit hold,
                              bit ereq, bit caddr, logic [31:0] eaddr,
                              bit evalid, logic [31:0] epc, logic [31:0] einst);
      vec_t v;
      v = '{rst: r, ce: ce, rdy: rdy, rv: rv, rpc: rpc, hold: hold, e_req: ereq,
            chk_addr: caddr, e_addr: eaddr, e_valid: evalid, e_pc: epc, e_inst: einst};
      return v;
   endfunction

   vec_t vq[$];

   initial begin
      rst = 1'b0; inst_ce = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; ack_hold = 1'b0; rst2 = 1'b0;

      //          rst ce rdy rv rpc           hold req ca addr          vld pc            inst
      // reset held three cycles
      vq.push_back(V(0, 1, 1, 0, 32'h0,        0,   0, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(0, 1, 1, 0, 32'h0,        0,   0, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(0, 1, 1, 0, 32'h0,        0,   0, 1, 32'h0,        0, 32'h0,        32'h0));
      // streaming with 1-cycle ack
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h4,        1, 32'h0,        32'hA5A5_0000));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h8,        1, 32'h4,        32'hA5A5_0004));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'hC,        1, 32'h8,        32'hA5A5_0008));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h10,       1, 32'hC,        32'hA5A5_000C));
      // backpressure from a fresh reset
      vq.push_back(V(0, 1, 0, 0, 32'h0,        0,   0, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 0, 0, 32'h0,        0,   1, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 0, 0, 32'h0,        0,   1, 1, 32'h4,        1, 32'h0,        32'hA5A5_0000));
      vq.push_back(V(1, 1, 0, 0, 32'h0,        0,   0, 0, 32'h0,        1, 32'h0,        32'hA5A5_0000));
      vq.push_back(V(1, 1, 0, 0, 32'h0,        0,   0, 0, 32'h0,        1, 32'h0,        32'hA5A5_0000));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h8,        1, 32'h4,        32'hA5A5_0004));
      // redirect while the 0x8 request waits three cycles for its ack
      vq.push_back(V(1, 1, 1, 1, 32'h101,      1,   1, 1, 32'h8,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        1,   1, 1, 32'h8,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        1,   1, 1, 32'h8,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   0, 0, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h100,      0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h104,      1, 32'h100,      32'hA5A5_0100));
      // redirect coincident with the ack for 0x104
      vq.push_back(V(1, 1, 1, 1, 32'h100,      0,   0, 0, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h100,      0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h104,      1, 32'h100,      32'hA5A5_0100));
      // inst_ce low: outstanding fetch still lands, no new issue
      vq.push_back(V(1, 0, 1, 0, 32'h0,        0,   0, 0, 32'h0,        1, 32'h104,      32'hA5A5_0104));
      vq.push_back(V(1, 0, 1, 0, 32'h0,        0,   0, 0, 32'h0,        0, 32'h0,        32'h0));
      // redirect in IDLE near the top of memory, then PC wrap
      vq.push_back(V(1, 1, 1, 1, 32'hFFFF_FFFB, 0,  0, 0, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h5A5A_FFF8));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'h5A5A_FFFC));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h4,        1, 32'h0,        32'hA5A5_0000));
      // reset during REQ with an ack present
      vq.push_back(V(0, 1, 1, 0, 32'h0,        0,   0, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h0,        0, 32'h0,        32'h0));
      // redirect into DROP, then a second redirect in the ack cycle
      vq.push_back(V(1, 1, 1, 1, 32'h40,       1,   1, 1, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 1, 32'h80,       0,   0, 0, 32'h0,        0, 32'h0,        32'h0));
      vq.push_back(V(1, 1, 1, 0, 32'h0,        0,   1, 1, 32'h80,       0, 32'h0,        32'h0));

      @(posedge clk);
      #1;
      foreach (vq[i]) begin
         rst            = vq[i].rst;
         inst_ce        = vq[i].ce;
         if_ready       = vq[i].rdy;
         redirect_valid = vq[i].rv;
         redirect_pc    = vq[i].rpc;
         ack_hold       = vq[i].hold;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vq[i].e_req});
         if (vq[i].chk_addr)
            chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].e_addr);
         chk($sformatf("v%0d if_valid", i), {31'b0, if_valid}, {31'b0, vq[i].e_valid});
         if (vq[i].e_valid || !vq[i].rst) begin
            chk($sformatf("v%0d if_pc", i), if_pc, vq[i].e_pc);
            chk($sformatf("v%0d if_inst", i), if_inst, vq[i].e_inst);
         end
      end

      // Non-default RESET_PC instance: wrap from 0xFFFF_FFFC to 0x0, then mid-REQ reset.
      rst2 = 1'b1;
      @(posedge clk);
      #1;
      chk("wrap req", {31'b0, req2}, 32'd1);
      chk("wrap addr", addr2, 32'hFFFF_FFFC);
      chk("wrap valid0", {31'b0, valid2}, 32'd0);
      @(posedge clk);
      #1;
      chk("wrap valid1", {31'b0, valid2}, 32'd1);
      chk("wrap pc0", pc2, 32'hFFFF_FFFC);
      chk("wrap inst0", inst2, 32'h5A5A_FFFC);
      chk("wrap addr1", addr2, 32'h0);
      @(posedge clk);
      #1;
      chk("wrap pc1", pc2, 32'h0);
      chk("wrap inst1", inst2, 32'hA5A5_0000);
      rst2 = 1'b0;
      @(posedge clk);
      #1;
      chk("wrap rst req", {31'b0, req2}, 32'd0);
      chk("wrap rst addr", addr2, 32'hFFFF_FFFC);
      chk("wrap rst valid", {31'b0, valid2}, 32'd0);
      chk("wrap rst pc", pc2, 32'h0);
      chk("wrap rst inst", inst2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC-increment logic. It owns the fetch PC, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs. It delivers them to the controller/decoder over a valid/ready interface. It also accepts a redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
inst_ce  in  1  fetch enable; 0 = issue no new requests
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word-aligned read address, stable while imem_req=1
imem_ack  in  1  memory completion; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
redirect_valid  in  1  one-cycle redirect pulse
redirect_pc  in  32  new fetch PC; bits[1:0] ignored (forced 0)
if_valid  out  1  buffer head valid
if_ready  in  1  consumer accepts head
if_inst  out  32  head instruction
if_pc  out  32  head instruction address

Behaviour:
- Reset (rst=0 at posedge): fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, buffer empty, if_valid=0, if_inst=0, if_pc=0. Reset overrides all other inputs, including mid-transaction; a pending ack after reset is ignored because req is low.
- imem_req and imem_addr are registered. Once raised, req and addr hold until the cycle imem_ack=1 is sampled with req=1. At most one request is outstanding.
- space = (count + outstanding) < BUF_DEPTH, where count accounts for a pop in the same cycle.
- States:
  IDLE: if redirect_valid, fetch_pc<=redirect_pc, flush buffer, stay IDLE. Else if inst_ce && space, go to REQ next cycle with imem_addr=fetch_pc.
  REQ: on ack with no redirect, push {fetch_pc, imem_rdata} and set fetch_pc<=fetch_pc+4. Then go REQ with the new addr if inst_ce && space (back-to-back issue allowed), else IDLE.
  REQ with redirect and no ack: fetch_pc<=redirect_pc, flush buffer, go DROP (req/addr held).
  REQ with redirect and ack in the same cycle: discard rdata, fetch_pc<=redirect_pc, flush, go IDLE.
  DROP: wait for ack; discard rdata, then go IDLE. A redirect in DROP updates fetch_pc and flushes; stay in DROP (or go IDLE if ack is in that cycle).
- Redirect has priority over push and pop. A flush empties the buffer; if_valid=0 in the next cycle.
- Buffer is a FIFO. Pop when if_valid && if_ready. Push and pop in the same cycle are legal, including when full; occupancy is unchanged.
- if_inst and if_pc are driven from the head entry. They are stable while if_valid && !if_ready.
- PC arithmetic is 32-bit modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
- inst_ce=0 blocks new issues only. An outstanding request still completes and is pushed.
- Latency: with a 1-cycle ack and if_ready=1, the first if_valid rises 2 cycles after rst deasserts. Steady-state throughput is 1 instruction per ack cycle.

Decomposition:
- Package if_pkg: PC_INCREMENT=32'h4, default RESET_PC, state encoding IDLE/REQ/DROP, localparam for the buffer entry width (64).
- One sub-module, if_fetch_buf: parameterised synchronous FIFO with push, pop, flush, count, full, empty and head data.

Test Plan:
- Reset hold rst=0 for 3 cycles with inst_ce=1 -> imem_req=0, if_valid=0. Release rst -> next cycle imem_req=1, imem_addr=0x0.
- Streaming: 1-cycle ack, rdata=addr^0xA5A5_0000, if_ready=1 -> if_pc sequence 0x0,0x4,0x8,0xC with matching if_inst, no gaps after the first.
- Backpressure: if_ready=0 -> exactly 2 entries (0x0,0x4) buffered and imem_req stays 0. Raise if_ready -> pops 0x0 then 0x4, next request addr=0x8.
- Redirect pending: redirect_pc=0x101 while req for 0x8 awaits ack (ack delayed 3 cycles) -> addr held 0x8 until ack, data not delivered, if_valid=0, next request addr=0x100.
- Redirect coincident with ack -> rdata dropped, next imem_addr=0x100, first delivered if_pc=0x100.
- Wrap and mid-reset: RESET_PC=0xFFFF_FFFC -> if_pc 0xFFFF_FFFC then 0x0. Asserting rst during REQ -> all outputs return to reset values next cycle.
